// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Two one-entry request slots (A: ALU, B: load) share the port with age-ordered, fair granting.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_reg,
  input  logic [DW-1:0]        a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [AW-1:0]        b_reg,
  input  logic [DW-1:0]        b_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wrreg,
  output logic [DW-1:0]        rf_indata,
  output logic [(1<<AW)-1:0]   pending,
  output logic                 idle,
  output logic [15:0]          wr_count
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  logic           r_full_a, r_full_b;
  logic [AW-1:0]  r_reg_a, r_reg_b;
  logic [DW-1:0]  r_data_a, r_data_b;
  logic           r_a_older;
  port_e          r_rr_last;
  logic           r_rf_we;
  logic [AW-1:0]  r_rf_wrreg;
  logic [DW-1:0]  r_rf_indata;
  logic [15:0]    r_wr_count;

  logic           w_grant_a, w_grant_b, w_grant_any;
  logic           w_fill_a, w_fill_b;
  logic           w_keep_a, w_keep_b;
  logic [(1<<AW)-1:0] w_pending;

  // Equal destinations must drain oldest-first; otherwise alternate ports.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_full_a && r_full_b) begin
      if (r_reg_a == r_reg_b) begin
        w_grant_a = r_a_older;
        w_grant_b = ~r_a_older;
      end else if (r_rr_last == PORT_B) begin
        w_grant_a = 1'b1;
      end else begin
        w_grant_b = 1'b1;
      end
    end else begin
      w_grant_a = r_full_a;
      w_grant_b = r_full_b;
    end
  end

  assign w_grant_any = w_grant_a | w_grant_b;

  assign a_ready = ~r_full_a | w_grant_a;
  assign b_ready = ~r_full_b | w_grant_b;

  // Writes to register 0 are accepted but never occupy a slot.
  assign w_fill_a = a_valid & a_ready & (a_reg != '0);
  assign w_fill_b = b_valid & b_ready & (b_reg != '0);
  assign w_keep_a = r_full_a & ~w_grant_a;
  assign w_keep_b = r_full_b & ~w_grant_b;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: slot payloads are reset too; they are plain flops, not a RAM, so clearing them is free of side effects.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full_a  <= 1'b0;
      r_full_b  <= 1'b0;
      r_reg_a   <= '0;
      r_reg_b   <= '0;
      r_data_a  <= '0;
      r_data_b  <= '0;
      r_a_older <= 1'b0;
      r_rr_last <= PORT_B;
    end else begin
      r_full_a <= w_fill_a | w_keep_a;
      r_full_b <= w_fill_b | w_keep_b;
      if (w_fill_a) begin
        r_reg_a  <= a_reg;
        r_data_a <= a_data;
      end
      if (w_fill_b) begin
        r_reg_b  <= b_reg;
        r_data_b <= b_data;
      end
      // A slot that survives the edge is older than anything that just arrived; simultaneous arrivals favour A.
      r_a_older <= w_keep_a | ~w_keep_b;
      if (w_grant_any) begin
        r_rr_last <= w_grant_a ? PORT_A : PORT_B;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rf_we     <= 1'b0;
      r_rf_wrreg  <= '0;
      r_rf_indata <= '0;
      r_wr_count  <= '0;
    end else begin
      r_rf_we <= w_grant_any;
      if (w_grant_any) begin
        r_rf_wrreg  <= w_grant_a ? r_reg_a  : r_reg_b;
        r_rf_indata <= w_grant_a ? r_data_a : r_data_b;
        r_wr_count  <= r_wr_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_pending = '0;
    if (r_full_a) w_pending[r_reg_a] = 1'b1;
    if (r_full_b) w_pending[r_reg_b] = 1'b1;
  end

  assign pending   = w_pending;
  assign rf_we     = r_rf_we;
  assign rf_wrreg  = r_rf_wrreg;
  assign rf_indata = r_rf_indata;
  assign wr_count  = r_wr_count;
  assign idle      = ~r_full_a & ~r_full_b & ~r_rf_we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed requests push expected writes,
// a negedge monitor pops and compares each register-file write.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        rf_we;
  logic [4:0]  rf_wrreg;
  logic [31:0] rf_indata;
  logic [31:0] pending;
  logic        idle;
  logic [15:0] wr_count;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .rf_we     (rf_we),
    .rf_wrreg  (rf_wrreg),
    .rf_indata (rf_indata),
    .pending   (pending),
    .idle      (idle),
    .wr_count  (wr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write", rf_wrreg, rf_indata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write", {27'd0, rf_wrreg, rf_indata}, {27'd0, e});
      end
    end
  end

  function automatic void expect_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endfunction

  // Entry and exit aligned 1 time unit after a rising edge.
  task automatic send_a(input logic [4:0] r, input logic [31:0] d);
    int n = 0;
    a_valid = 1'b1; a_reg = r; a_data = d;
    forever begin
      @(negedge clock);
      if (a_ready) break;
      n++;
      if (n > 50) begin
        check("a_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clock); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] r, input logic [31:0] d);
    int n = 0;
    b_valid = 1'b1; b_reg = r; b_data = d;
    forever begin
      @(negedge clock);
      if (b_ready) break;
      n++;
      if (n > 50) begin
        check("b_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clock); #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;

    // Reset state
    @(posedge clock); #1;
    check("rst_a_ready", 64'(a_ready), 64'd1);
    check("rst_b_ready", 64'(b_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);

    // Single write: reg 3 = 0x11
    do_reset();
    expect_wr(5'd3, 32'h11);
    send_a(5'd3, 32'h11);
    @(negedge clock);
    check("t1_pending_set", 64'(pending), 64'h8);
    check("t1_idle_busy", 64'(idle), 64'd0);
    check("t1_rf_we_lat", 64'(rf_we), 64'd0);
    @(negedge clock);
    check("t1_rf_we_high", 64'(rf_we), 64'd1);
    check("t1_pending_clr", 64'(pending), 64'd0);
    check("t1_wr_count", 64'(wr_count), 64'd1);
    @(negedge clock);
    check("t1_rf_we_once", 64'(rf_we), 64'd0);
    check("t1_idle_back", 64'(idle), 64'd1);
    wait_drain("t1");

    // Both ports streaming: strict A,B alternation from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'd4, 32'hA0 + 32'(i));
      expect_wr(5'd5, 32'hB0 + 32'(i));
    end
    fork
      for (int i = 0; i < 4; i++) send_a(5'd4, 32'hA0 + 32'(i));
      for (int j = 0; j < 4; j++) send_b(5'd5, 32'hB0 + 32'(j));
    join
    wait_drain("t2");
    check("t2_wr_count", 64'(wr_count), 64'd8);

    // B fills reg 7 one cycle before A fills reg 7
    do_reset();
    expect_wr(5'd7, 32'h1);
    expect_wr(5'd7, 32'h2);
    send_b(5'd7, 32'h1);
    send_a(5'd7, 32'h2);
    wait_drain("t3");

    // Same register in both slots, A older, round-robin would pick B
    do_reset();
    expect_wr(5'd9, 32'h90);
    expect_wr(5'd7, 32'h71);
    expect_wr(5'd7, 32'h72);
    send_a(5'd9, 32'h90);
    fork
      send_a(5'd7, 32'h71);
      send_b(5'd7, 32'h72);
    join
    wait_drain("t4");
    check("t4_wr_count", 64'(wr_count), 64'd3);

    // Register 0 is dropped
    send_a(5'd0, 32'hDEAD);
    @(negedge clock);
    check("t5_pending0", 64'(pending), 64'd0);
    @(negedge clock);
    check("t5_rf_we", 64'(rf_we), 64'd0);
    check("t5_wr_count", 64'(wr_count), 64'd3);
    check("t5_idle", 64'(idle), 64'd1);
    @(posedge clock); #1;

    // Reset while both slots are full and a write is on the port
    do_reset();
    expect_wr(5'd10, 32'h100);
    send_a(5'd10, 32'h100);
    fork
      send_a(5'd12, 32'h120);
      send_b(5'd11, 32'h110);
    join
    @(negedge clock);
    check("t6_pending_full", 64'(pending), 64'h1800);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rf_we", 64'(rf_we), 64'd0);
    check("t6_pending", 64'(pending), 64'd0);
    check("t6_rf_wrreg", 64'(rf_wrreg), 64'd0);
    check("t6_rf_indata", 64'(rf_indata), 64'd0);
    check("t6_wr_count", 64'(wr_count), 64'd0);
    check("t6_idle", 64'(idle), 64'd1);
    check("t6_readies", 64'({a_ready, b_ready}), 64'd3);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("t6_no_stale", 64'(wr_count), 64'd0);
    check("t6_idle_after", 64'(idle), 64'd1);
    wait_drain("t6");

    // 65536 back-to-back writes wrap the counter
    do_reset();
    for (int i = 0; i < 65536; i++) expect_wr(5'((i % 31) + 1), 32'(i));
    for (int i = 0; i < 65536; i++) send_a(5'((i % 31) + 1), 32'(i));
    wait_drain("t7");
    check("t7_wrap", 64'(wr_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
